// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one inter-stage pipeline register: upstream and downstream
// ready/valid, stage controls (hold/flush) and the bubble counter.
interface pipe_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 4,
  parameter int CNT_W      = 16
);
  localparam int PW = DATA_W * NUM_FIELDS;

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          hold;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output in_valid, in_data, hold, flush, out_ready,
    input  in_ready, out_valid, out_data, bubble_cnt
  );

  modport slave (
    input  in_valid, in_data, hold, flush, out_ready,
    output in_ready, out_valid, out_data, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with optional 2-entry skid buffer,
// hold/flush controls and a saturating flush (bubble) counter.

module pipe_stage_reg_chk #(
  parameter int            PW          = 128,
  parameter logic [PW-1:0] BUBBLE_WORD = {PW{1'b0}}
) (
  input logic          clk,
  input logic          rst,
  input logic          out_valid,
  input logic          skid_valid,
  input logic [PW-1:0] out_data,
  input logic [PW-1:0] skid_data
);
  a_out_empty_bubble: assert property (@(posedge clk) disable iff (rst)
    (!out_valid |-> (out_data == BUBBLE_WORD)))
    else $error("stage checker: empty output entry carries a payload");

  a_skid_empty_bubble: assert property (@(posedge clk) disable iff (rst)
    (!skid_valid |-> (skid_data == BUBBLE_WORD)))
    else $error("stage checker: empty skid entry carries a payload");

  a_skid_behind_out: assert property (@(posedge clk) disable iff (rst)
    (skid_valid |-> out_valid))
    else $error("stage checker: skid entry valid while output entry empty");
endmodule

module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_FIELDS = 4,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);
  localparam int            PW          = DATA_W * NUM_FIELDS;
  localparam logic [PW-1:0] BUBBLE_WORD = {NUM_FIELDS{BUBBLE_VAL}};
  localparam bit            SKID_EN     = (SKID != 0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } occ_e;

  typedef enum logic [1:0] {
    OUT_KEEP   = 2'd0,
    OUT_IN     = 2'd1,
    OUT_SKID   = 2'd2,
    OUT_BUBBLE = 2'd3
  } out_sel_e;

  typedef enum logic [1:0] {
    SK_KEEP   = 2'd0,
    SK_IN     = 2'd1,
    SK_BUBBLE = 2'd2
  } skid_sel_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  occ_e             state_r;
  occ_e             next_state_s;
  out_sel_e         out_sel_s;
  skid_sel_e        skid_sel_s;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic [PW-1:0]    out_data_r;
  logic [PW-1:0]    skid_data_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic             in_ready_s;
  logic             acc_s;
  logic             drn_s;

  // Without a skid entry the stage may accept whenever the output slot frees this cycle.
  assign in_ready_s = SKID_EN ? in_ready_r
                              : (!out_valid_r | (bus.out_ready & !bus.hold));
  assign acc_s      = bus.in_valid & in_ready_s & !bus.flush;
  assign drn_s      = out_valid_r & bus.out_ready & !bus.hold;

  // Occupancy register; valid and ready flags are registered decodes of the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= next_state_s;
      out_valid_r  <= (next_state_s != ST_EMPTY);
      skid_valid_r <= (next_state_s == ST_FULL2);
      in_ready_r   <= (next_state_s != ST_FULL2);
    end
  end

  // Next occupancy; flush dominates every other control.
  always_comb begin
    next_state_s = state_r;
    if (bus.flush) begin
      next_state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            next_state_s = ST_FULL1;
          end else begin
            next_state_s = ST_EMPTY;
          end
        end
        ST_FULL1: begin
          if (acc_s && !drn_s && SKID_EN) begin
            next_state_s = ST_FULL2;
          end else if (!acc_s && drn_s) begin
            next_state_s = ST_EMPTY;
          end else begin
            next_state_s = ST_FULL1;
          end
        end
        ST_FULL2: begin
          if (drn_s) begin
            next_state_s = ST_FULL1;
          end else begin
            next_state_s = ST_FULL2;
          end
        end
        default: begin
          next_state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Datapath load selects; the skid entry only ever holds the younger payload.
  always_comb begin
    out_sel_s  = OUT_KEEP;
    skid_sel_s = SK_KEEP;
    if (bus.flush) begin
      out_sel_s  = OUT_BUBBLE;
      skid_sel_s = SK_BUBBLE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            out_sel_s = OUT_IN;
          end else begin
            out_sel_s = OUT_KEEP;
          end
        end
        ST_FULL1: begin
          if (acc_s && drn_s) begin
            out_sel_s = OUT_IN;
          end else if (acc_s && SKID_EN) begin
            skid_sel_s = SK_IN;
          end else if (drn_s) begin
            out_sel_s = OUT_BUBBLE;
          end else begin
            out_sel_s = OUT_KEEP;
          end
        end
        ST_FULL2: begin
          if (drn_s) begin
            out_sel_s  = OUT_SKID;
            skid_sel_s = SK_BUBBLE;
          end else begin
            out_sel_s = OUT_KEEP;
          end
        end
        default: begin
          out_sel_s  = OUT_BUBBLE;
          skid_sel_s = SK_BUBBLE;
        end
      endcase
    end
  end

  // Output and skid payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= BUBBLE_WORD;
      skid_data_r <= BUBBLE_WORD;
    end else begin
      case (out_sel_s)
        OUT_IN:     out_data_r <= bus.in_data;
        OUT_SKID:   out_data_r <= skid_data_r;
        OUT_BUBBLE: out_data_r <= BUBBLE_WORD;
        default:    out_data_r <= out_data_r;
      endcase
      case (skid_sel_s)
        SK_IN:     skid_data_r <= bus.in_data;
        SK_BUBBLE: skid_data_r <= BUBBLE_WORD;
        default:   skid_data_r <= skid_data_r;
      endcase
    end
  end

  // Saturating count of flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      bubble_cnt_r <= sat_inc(bubble_cnt_r);
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.bubble_cnt = bubble_cnt_r;

  pipe_stage_reg_chk #(
    .PW          (PW),
    .BUBBLE_WORD (BUBBLE_WORD)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_r),
    .skid_valid (skid_valid_r),
    .out_data   (out_data_r),
    .skid_data  (skid_data_r)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 stage and a SKID=0/CNT_W=2 stage share stimulus
// and are compared against a queue-based occupancy model, plus directed vectors.
module tb_pipe_stage_reg;
  localparam int PW = 128;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_stage_reg_if #(.DATA_W(32), .NUM_FIELDS(4), .CNT_W(16)) if1 ();
  pipe_stage_reg_if #(.DATA_W(32), .NUM_FIELDS(4), .CNT_W(2))  if0 ();

  pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(4), .SKID(1), .BUBBLE_VAL(32'h0), .CNT_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  pipe_stage_reg #(.DATA_W(32), .NUM_FIELDS(4), .SKID(0), .BUBBLE_VAL(32'h0), .CNT_W(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents of each stage and flush counts
  logic [PW-1:0] q1[$];
  logic [PW-1:0] q0[$];
  int            cnt1;
  int            cnt0;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        hold;
    logic        flush;
    logic        ordy;
    logic        exp_ir1;
    logic        exp_ir0;
    logic        exp_ov1;
    logic [31:0] exp_pc1;
  } vec_t;

  vec_t vt[10];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    return {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] pc, input logic h,
                               input logic f, input logic r, input logic ir1,
                               input logic ir0, input logic ov1, input logic [31:0] epc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.hold = h; v.flush = f; v.ordy = r;
    v.exp_ir1 = ir1; v.exp_ir0 = ir0; v.exp_ov1 = ov1; v.exp_pc1 = epc;
    return v;
  endfunction

  task automatic set_in(input logic iv, input logic [PW-1:0] d, input logic h,
                        input logic f, input logic r);
    if1.in_valid = iv; if1.in_data = d; if1.hold = h; if1.flush = f; if1.out_ready = r;
    if0.in_valid = iv; if0.in_data = d; if0.hold = h; if0.flush = f; if0.out_ready = r;
  endtask

  task automatic check_outputs();
    chk_bit ("ov_skid",    if1.out_valid, q1.size() != 0);
    chk_bit ("ov_noskid",  if0.out_valid, q0.size() != 0);
    chk_word("data_skid",  if1.out_data,  (q1.size() != 0) ? q1[0] : {PW{1'b0}});
    chk_word("data_noskid", if0.out_data, (q0.size() != 0) ? q0[0] : {PW{1'b0}});
    chk_int ("cnt_skid",   int'(if1.bubble_cnt), cnt1);
    chk_int ("cnt_noskid", int'(if0.bubble_cnt), cnt0);
  endtask

  // One clock: apply inputs, check ready before the edge, advance the model, check after.
  task automatic step(input logic iv, input logic [PW-1:0] d, input logic h, input logic f,
                      input logic r, output logic ir1_pre, output logic ir0_pre);
    logic mir1, mir0, acc1, acc0, drn1, drn0;
    set_in(iv, d, h, f, r);
    #2;
    mir1 = (q1.size() < 2);
    mir0 = (q0.size() == 0) || (r && !h);
    ir1_pre = if1.in_ready;
    ir0_pre = if0.in_ready;
    chk_bit("in_ready_skid", if1.in_ready, mir1);
    chk_bit("in_ready_noskid", if0.in_ready, mir0);
    acc1 = iv && mir1 && !f;
    acc0 = iv && mir0 && !f;
    drn1 = (q1.size() != 0) && r && !h;
    drn0 = (q0.size() != 0) && r && !h;
    @(posedge clk);
    #1;
    if (f) begin
      q1.delete();
      q0.delete();
      if (cnt1 < 65535) cnt1++;
      if (cnt0 < 3) cnt0++;
    end else begin
      if (drn1) void'(q1.pop_front());
      if (acc1) q1.push_back(d);
      if (drn0) void'(q0.pop_front());
      if (acc0) q0.push_back(d);
    end
    check_outputs();
  endtask

  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
    chk_bit ("rst_ov_skid",   if1.out_valid, 1'b0);
    chk_bit ("rst_ov_noskid", if0.out_valid, 1'b0);
    chk_word("rst_data_skid", if1.out_data, {PW{1'b0}});
    chk_word("rst_data_noskid", if0.out_data, {PW{1'b0}});
    chk_int ("rst_cnt_skid",  int'(if1.bubble_cnt), 0);
    chk_int ("rst_cnt_noskid", int'(if0.bubble_cnt), 0);
    chk_bit ("rst_ir_skid",   if1.in_ready, 1'b1);
    chk_bit ("rst_ir_noskid", if0.in_ready, 1'b1);
    set_in(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] hd;
    logic [PW-1:0] fd;
    logic ir1p, ir0p;
    checks = 0;
    failures = 0;
    cnt1 = 0;
    cnt0 = 0;
    rst = 1'b1;
    set_in(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b0);

    //          iv    pc          h     f     r     ir1   ir0   ov1   pc1
    vt[0] = mkv(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    vt[1] = mkv(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104);
    vt[2] = mkv(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h108);
    vt[3] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vt[4] = mkv(1'b1, 32'hA0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0);
    vt[5] = mkv(1'b1, 32'hA4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0);
    vt[6] = mkv(1'b1, 32'hA8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0);
    vt[7] = mkv(1'b1, 32'hA8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA4);
    vt[8] = mkv(1'b1, 32'hA8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA8);
    vt[9] = mkv(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(vt[i].iv, mk(vt[i].pc), vt[i].hold, vt[i].flush, vt[i].ordy, ir1p, ir0p);
      chk_bit("tbl_ir_skid", ir1p, vt[i].exp_ir1);
      chk_bit("tbl_ir_noskid", ir0p, vt[i].exp_ir0);
      chk_bit("tbl_ov_skid", if1.out_valid, vt[i].exp_ov1);
      chk_word("tbl_pc_skid", {96'h0, if1.out_data[31:0]}, {96'h0, vt[i].exp_pc1});
    end

    // Hold: output frozen bit-exact while downstream is ready, then one drain
    hd = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0200};
    step(1'b1, hd, 1'b0, 1'b0, 1'b0, ir1p, ir0p);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, {PW{1'b0}}, 1'b1, 1'b0, 1'b1, ir1p, ir0p);
      chk_bit("hold_ov", if1.out_valid, 1'b1);
      chk_word("hold_data", if1.out_data, hd);
    end
    step(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b1, ir1p, ir0p);
    chk_bit("hold_release_drain", if1.out_valid, 1'b0);

    // Async reset mid-cycle with a payload in flight
    step(1'b1, mk(32'h300), 1'b0, 1'b0, 1'b0, ir1p, ir0p);
    mid_reset();

    // Flush from FULL2 together with hold and an offered payload
    step(1'b1, mk(32'h10), 1'b0, 1'b0, 1'b0, ir1p, ir0p);
    step(1'b1, mk(32'h14), 1'b0, 1'b0, 1'b0, ir1p, ir0p);
    fd = {4{32'h0000_0055}};
    step(1'b1, fd, 1'b1, 1'b1, 1'b1, ir1p, ir0p);
    chk_bit("flush_ov", if1.out_valid, 1'b0);
    chk_word("flush_data", if1.out_data, {PW{1'b0}});
    chk_bit("flush_ir_next", if1.in_ready, 1'b1);
    chk_int("flush_cnt", int'(if1.bubble_cnt), 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b1, ir1p, ir0p);
      chk_bit("flush_dropped", if1.out_valid, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, {PW{1'b0}}, 1'b0, 1'b1, 1'b1, ir1p, ir0p);
    end
    chk_int("sat_cnt_w2", int'(if0.bubble_cnt), 3);
    chk_int("cnt_w16", int'(if1.bubble_cnt), 5);

    // SKID=0 full throughput with combinational ready
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(32'h400 + 32'(4 * i)), 1'b0, 1'b0, 1'b1, ir1p, ir0p);
      chk_bit("noskid_tput_ir", ir0p, 1'b1);
      chk_word("noskid_tput_pc", {96'h0, if0.out_data[31:0]}, {96'h0, 32'h400 + 32'(4 * i)});
    end

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, ir1p, ir0p);
    end
    mid_reset();
    step(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b1, ir1p, ir0p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core; the generalised replacement for the fixed fetch/decode/execute stage registers.
- Carries NUM_FIELDS packed payload fields with a valid bit and upstream/downstream ready/valid handshake.
- Separates hold (freeze contents) from flush (insert bubble). Optional 2-entry skid buffer registers in_ready to break the ready timing path.
- Counts inserted bubbles for performance debug.

Parameters:
DATA_W, 32, width of one payload field (pc, rs1_data, rs2_data, sext_imme, ...)
NUM_FIELDS, 4, number of packed fields; payload width PW = DATA_W*NUM_FIELDS
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
BUBBLE_VAL, 0, per-field value driven or loaded for an empty or flushed slot (replicated across all fields)
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  PW  upstream payload, field k at [k*DATA_W +: DATA_W]
hold  input  1  stall: freeze output entry, no downstream transfer
flush  input  1  jump/branch or hazard: discard all contents, insert bubble
out_valid  output  1  output entry valid
out_ready  input  1  downstream can accept
out_data  output  PW  output payload; BUBBLE_VAL fields when out_valid=0
bubble_cnt  output  CNT_W  count of flush cycles, saturating

Behaviour:
- Reset (async, rst=1): out_valid=0; skid entry invalid; out_data and skid data = BUBBLE_VAL; bubble_cnt=0.
  - in_ready=1 when SKID=1.
  - in_ready = !out_valid = 1 when SKID=0.
- Transfers:
  - Accept (acc) = in_valid & in_ready & !flush.
  - Drain (drn) = out_valid & out_ready & !hold.
- Latency: one cycle from accept to out_valid when the output entry is empty or draining.
- SKID=0:
  - in_ready = !out_valid | (out_ready & !hold).
  - On acc, output register loads in_data and out_valid=1.
  - On drn without acc, out_valid=0 and data = BUBBLE_VAL.
- SKID=1, states by occupancy:
  - EMPTY (out invalid, skid invalid):
    - acc -> FULL1; output loads in_data.
  - FULL1 (out valid, skid invalid):
    - acc & drn -> FULL1; output loads in_data.
    - acc & !drn -> FULL2; skid loads in_data.
    - !acc & drn -> EMPTY.
  - FULL2 (both valid):
    - in_ready=0.
    - drn -> FULL1; output loads skid; skid = BUBBLE_VAL.
  - in_ready is a register, equal to "next state != FULL2".
  - Ordering: FIFO. Output is always older than skid.
- hold:
  - Blocks drain only. Upstream may still fill the skid while holding.
  - Output contents are held bit-exact.
- flush:
  - Synchronous, highest priority over hold, acc and drn.
  - Next cycle: out_valid=0, skid invalid, all data = BUBBLE_VAL.
  - in_data offered in the flush cycle is dropped. in_ready may be 1 in that cycle, but no transfer counts.
  - Next cycle in_ready=1.
- flush & hold together: flush wins; stage empties.
- bubble_cnt: +1 on every clock with flush=1; saturates at all-ones; never wraps.
- out_data is driven from a register only; no combinational path from in_data to out_data.
- rst mid-stream: both entries discarded immediately; no partial payload is visible.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> out_valid=0, out_data=0 in all fields, bubble_cnt=0, in_ready=1 (both SKID modes).
- Streaming, SKID=1, out_ready=1, hold=0: feed pc=0x100,0x104,0x108 back-to-back -> out_data pc field 0x100,0x104,0x108 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0 and feed 0xA0, 0xA4, 0xA8 -> after 0xA4, in_ready=0 and 0xA8 is not accepted. Then out_ready=1 -> outputs 0xA0, 0xA4, then 0xA8 once re-offered; nothing lost or duplicated.
- Hold: out_valid=1 with rs1=0xDEADBEEF; hold=1 for 3 cycles with out_ready=1 -> out_data constant, no drain. Release -> drains exactly once.
- Flush: stage in FULL2 with flush=1, in_valid=1, in_data=0x55, hold=1 -> next cycle out_valid=0, data=BUBBLE_VAL, in_ready=1, 0x55 never appears, bubble_cnt=1.
- Saturation and SKID=0: CNT_W=2 with 5 flush cycles -> bubble_cnt=3. SKID=0 with out_valid=1, out_ready=1, hold=0 -> in_ready=1 combinationally and full throughput.
